// File: rtl/fc3_argmax_pkg.sv
// Shared types and defaults for the FC3 class-score argmax block.
package fc3_argmax_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam int unsigned NumClassDefault = 10;
  localparam int unsigned DwDefault       = 16;
  localparam int unsigned IdxWDefault     = 4;

  // Bit stride between adjacent class scores in the packed input frame.
  localparam int unsigned ScoreStride = DwDefault;

endpackage

// File: rtl/fc3_argmax_cmp.sv
// Signed strict-greater compare and select of one candidate score against the running best.
module argmax_cmp #(
  parameter int unsigned DW    = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic signed [DW-1:0]    i_cand,
  input  logic        [IDX_W-1:0] i_cand_idx,
  input  logic signed [DW-1:0]    i_best,
  input  logic        [IDX_W-1:0] i_best_idx,
  output logic signed [DW-1:0]    o_new_best,
  output logic        [IDX_W-1:0] o_new_idx
);

  logic w_gt;

  // Strictly greater only, so ties keep the earlier (lower) index.
  assign w_gt       = i_cand > i_best;
  assign o_new_best = w_gt ? i_cand : i_best;
  assign o_new_idx  = w_gt ? i_cand_idx : i_best_idx;

endmodule

// File: rtl/fc3_argmax.sv
// Captures a frame of class scores, scans them one per cycle and returns the argmax
// through a valid/ready handshake.
module fc3_argmax
  import fc3_argmax_pkg::*;
#(
  parameter int unsigned NUM_CLASS = NumClassDefault,
  parameter int unsigned DW        = ScoreStride,
  parameter int unsigned IDX_W     = IdxWDefault
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_scores_valid,
  input  logic [NUM_CLASS*DW-1:0] i_scores_in,
  output logic                    o_busy,
  output logic                    o_result_valid,
  input  logic                    i_result_ready,
  output logic [IDX_W-1:0]        o_result_idx,
  output logic [DW-1:0]           o_result_score,
  output logic                    o_overrun
);

  state_e             r_state;
  state_e             w_state_next;
  logic [DW-1:0]      r_buf [NUM_CLASS];
  logic [IDX_W-1:0]   r_cnt;
  logic [DW-1:0]      r_best_score;
  logic [IDX_W-1:0]   r_best_idx;
  logic [IDX_W-1:0]   r_result_idx;
  logic [DW-1:0]      r_result_score;
  logic               r_overrun;

  logic               w_accept;
  logic               w_drop;
  logic               w_last;
  logic [DW-1:0]      w_cand;
  logic [DW-1:0]      w_new_best;
  logic [IDX_W-1:0]   w_new_idx;

  // A new frame is taken in IDLE, or in HOLD when the current result leaves this cycle.
  assign w_accept = i_scores_valid &&
                    ((r_state == StIdle) || ((r_state == StHold) && i_result_ready));
  assign w_drop   = i_scores_valid && !w_accept;
  assign w_last   = (r_cnt == IDX_W'(NUM_CLASS - 1));
  assign w_cand   = r_buf[r_cnt];

  argmax_cmp #(
    .DW    (DW),
    .IDX_W (IDX_W)
  ) u_cmp (
    .i_cand     (w_cand),
    .i_cand_idx (r_cnt),
    .i_best     (r_best_score),
    .i_best_idx (r_best_idx),
    .o_new_best (w_new_best),
    .o_new_idx  (w_new_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_scores_valid) w_state_next = StScan;
      StScan:  if (w_last) w_state_next = StHold;
      StHold:  if (i_result_ready) w_state_next = i_scores_valid ? StScan : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_busy         = (r_state != StIdle);
    o_result_valid = (r_state == StHold);
    o_result_idx   = r_result_idx;
    o_result_score = r_result_score;
    o_overrun      = r_overrun;
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        r_buf[k] <= i_scores_in[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt          <= '0;
      r_best_score   <= '0;
      r_best_idx     <= '0;
      r_result_idx   <= '0;
      r_result_score <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      if (w_accept) begin
        r_cnt        <= IDX_W'(1);
        r_best_score <= i_scores_in[DW-1:0];
        r_best_idx   <= '0;
      end else if (r_state == StScan) begin
        r_best_score <= w_new_best;
        r_best_idx   <= w_new_idx;
        if (w_last) begin
          r_result_idx   <= w_new_idx;
          r_result_score <= w_new_best;
          r_cnt          <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc3_argmax.sv
// Scoreboard bench for fc3_argmax: directed frames push expected results, a monitor
// pops and compares on every accepted handshake.
module tb_fc3_argmax;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] score;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scores_valid = 1'b0;
  logic [159:0]  scores_in = '0;
  logic          busy;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [3:0]    result_idx;
  logic [15:0]   result_score;
  logic          overrun;

  exp_t          exp_q [$];
  logic [15:0]   fr [10];
  int            n_checks = 0;
  int            n_errors = 0;
  int            ov_cnt = 0;

  fc3_argmax u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_scores_valid (scores_valid),
    .i_scores_in    (scores_in),
    .o_busy         (busy),
    .o_result_valid (result_valid),
    .i_result_ready (result_ready),
    .o_result_idx   (result_idx),
    .o_result_score (result_score),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (overrun) ov_cnt <= ov_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [3:0] idx, input logic [15:0] score);
    exp_t e;
    e.idx   = idx;
    e.score = score;
    exp_q.push_back(e);
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int k = 0; k < 10; k++) fr[k] = v;
  endtask

  task automatic drive_frame();
    for (int k = 0; k < 10; k++) scores_in[k*16 +: 16] = fr[k];
    scores_valid = 1'b1;
  endtask

  // Returns at #1 after the edge that samples the pulse.
  task automatic send_frame();
    drive_frame();
    @(posedge clk); #1;
    scores_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!result_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle reached", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compares each result at the cycle it is accepted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result idx", {28'd0, result_idx}, {28'd0, e.idx});
          check("result score", {16'd0, result_score}, {16'd0, e.score});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int bcnt;
    int ov0;
    bit stable;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset valid", {31'd0, result_valid}, 32'd0);
    check("reset idx", {28'd0, result_idx}, 32'd0);
    check("reset score", {16'd0, result_score}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame, sink always ready: latency and busy length.
    result_ready = 1'b1;
    fr[0] = 16'h0100; fr[1] = 16'hFF00; fr[2] = 16'h0645; fr[3] = 16'h0010;
    fr[4] = 16'h0000; fr[5] = 16'h0000; fr[6] = 16'h0000; fr[7] = 16'h0000;
    fr[8] = 16'h0000; fr[9] = 16'h0200;
    push_exp(4'd2, 16'h0645);
    send_frame();
    lat = -1;
    bcnt = 0;
    for (int k = 0; k < 60 && busy; k++) begin
      if (result_valid && lat < 0) lat = k;
      bcnt++;
      @(posedge clk); #1;
    end
    check("single latency", lat, 32'd9);
    check("single busy cycles", bcnt, 32'd10);

    // Tie between two maxima: lowest index wins.
    set_all(16'hF000);
    fr[3] = 16'h7FFF;
    fr[7] = 16'h7FFF;
    push_exp(4'd3, 16'h7FFF);
    send_frame();
    wait_result(lat);
    check("tie latency", lat, 32'd9);
    wait_idle();

    // All most-negative.
    set_all(16'h8000);
    push_exp(4'd0, 16'h8000);
    send_frame();
    wait_result(lat);
    wait_idle();

    // Backpressure with a dropped frame during the hold.
    result_ready = 1'b0;
    for (int k = 0; k < 10; k++) fr[k] = 16'(k * 16);
    fr[5] = 16'h1234;
    push_exp(4'd5, 16'h1234);
    send_frame();
    wait_result(lat);
    check("hold latency", lat, 32'd9);
    ov0 = ov_cnt;
    stable = 1'b1;
    set_all(16'h0000);
    fr[0] = 16'h7FFF;
    for (int i = 0; i < 20; i++) begin
      if (result_valid !== 1'b1 || result_idx !== 4'd5 || result_score !== 16'h1234)
        stable = 1'b0;
      if (i == 10) drive_frame();
      else scores_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("hold stable", {31'd0, stable}, 32'd1);
    check("hold overrun pulses", ov_cnt - ov0, 32'd1);
    result_ready = 1'b1;
    @(posedge clk); #1;
    check("valid drops after accept", {31'd0, result_valid}, 32'd0);
    check("idx kept after accept", {28'd0, result_idx}, 32'd5);
    check("score kept after accept", {16'd0, result_score}, 32'h1234);

    // Back-to-back: accept a new frame in the same cycle the result leaves.
    result_ready = 1'b0;
    set_all(16'h0001);
    fr[1] = 16'h0300;
    push_exp(4'd1, 16'h0300);
    send_frame();
    wait_result(lat);
    ov0 = ov_cnt;
    set_all(16'hFFFF);
    fr[9] = 16'h0001;
    push_exp(4'd9, 16'h0001);
    drive_frame();
    result_ready = 1'b1;
    @(posedge clk); #1;
    scores_valid = 1'b0;
    check("b2b valid low", {31'd0, result_valid}, 32'd0);
    check("b2b busy", {31'd0, busy}, 32'd1);
    wait_result(lat);
    check("b2b latency", lat, 32'd9);
    wait_idle();
    check("b2b no overrun", ov_cnt - ov0, 32'd0);

    // Frame arriving mid-scan is dropped.
    set_all(16'h0001);
    fr[4] = 16'h7000;
    push_exp(4'd4, 16'h7000);
    ov0 = ov_cnt;
    send_frame();
    repeat (3) begin
      @(posedge clk); #1;
    end
    set_all(16'h0000);
    fr[0] = 16'h7FFF;
    send_frame();
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("scan overrun pulses", ov_cnt - ov0, 32'd1);
    check("scan drop stays idle", {31'd0, busy}, 32'd0);

    // Reset mid-scan aborts the frame.
    set_all(16'h0002);
    fr[8] = 16'h5555;
    send_frame();
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset valid", {31'd0, result_valid}, 32'd0);
    check("midreset idx", {28'd0, result_idx}, 32'd0);
    check("midreset score", {16'd0, result_score}, 32'd0);
    set_all(16'hFFF0);
    fr[7] = 16'h0042;
    push_exp(4'd7, 16'h0042);
    send_frame();
    wait_result(lat);
    check("post-reset latency", lat, 32'd9);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fc3_argmax.md
Name: fc3_argmax

Overview:
- Consumes the ten 16-bit signed class scores produced by the final fully-connected layer and reports the winning class index and its score.
- Captures all scores in one cycle on a valid pulse, then scans them serially, one comparison per cycle.
- Presents the result with a valid/ready handshake to the downstream result sink (display/UART).

Parameters:
- NUM_CLASS, 10, number of class scores per frame.
- DW, 16, score width; two's-complement fixed point, same format as the layer outputs.
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASS.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- scores_valid  input  1  single-cycle pulse: scores_in holds a complete frame this cycle.
- scores_in  input  NUM_CLASS*DW  class k at bits [k*DW +: DW]; class0 in the LSBs.
- busy  output  1  high whenever state is not IDLE.
- result_valid  output  1  result_idx and result_score are valid; held until accepted.
- result_ready  input  1  sink accepts the result when result_valid && result_ready.
- result_idx  output  IDX_W  index (0..NUM_CLASS-1) of the maximum score.
- result_score  output  DW  maximum score value.
- overrun  output  1  one-cycle pulse when scores_valid arrives and is dropped.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, result_valid=0, result_idx=0, result_score=0, overrun=0; scan counter=0.
  - Reset mid-scan or mid-hold aborts the frame; no result is issued.
- Score buffer: NUM_CLASS x DW registers, loaded only on frame acceptance.
- States:
  - IDLE:
    - On scores_valid: load the buffer; best_score=scores_in[class0]; best_idx=0; cnt=1; go to SCAN.
  - SCAN:
    - Each cycle compare buf[cnt] with best_score as signed values.
    - If strictly greater, update best_score and best_idx=cnt.
    - If cnt==NUM_CLASS-1, go to HOLD; else cnt=cnt+1.
  - HOLD:
    - result_valid=1; result_idx and result_score reflect best_idx and best_score, stable while held.
    - On result_ready: result_valid deasserts next cycle and state returns to IDLE.
    - If scores_valid is also high in the same cycle, accept the new frame (load buffer, cnt=1) and go directly to SCAN; result_valid=0 next cycle.
- Latency: scores_valid sampled at edge E0 leads to result_valid=1 after edge E0+NUM_CLASS-1 (9 scan cycles for NUM_CLASS=10). A frame therefore occupies 10 cycles when the sink is always ready.
- Tie rule: only a strictly greater score replaces the current best, so the lowest index wins ties.
- Signed compare: 16'h8000 is the most negative value and 16'h7FFF the most positive. No arithmetic is performed; no widening is needed.
- Dropped frames: scores_valid in SCAN, or in HOLD without result_ready, is ignored; overrun pulses high for 1 cycle. Buffer and best_* are unaffected.
- result_ready outside HOLD has no effect.
- Output registers: result_idx and result_score change only when entering HOLD. They keep their last value after the handshake until the next HOLD.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, SCAN=2'd1, HOLD=2'd2);
  - defaults for NUM_CLASS, DW, IDX_W;
  - a score-slice helper constant for the DW stride.
- One natural sub-module: argmax_cmp. It is combinational and computes a signed strict-greater compare plus select, with inputs cand, cand_idx, best, best_idx and outputs new_best, new_idx.
- Everything else stays in fc3_argmax: FSM, counter, buffer, output registers.

Test Plan:
- Single frame: scores {0x0100,0xFF00,0x0645,0x0010,0,0,0,0,0,0x0200}, result_ready=1 -> result_valid high exactly 9 cycles after the pulse; idx=2, score=0x0645; busy high for 10 cycles.
- Signed and tie handling: all scores 0xF000 except class3 and class7 = 0x7FFF -> idx=3, score=0x7FFF. Frame with all 0x8000 -> idx=0, score=0x8000.
- Backpressure: result_ready=0 for 20 cycles after result_valid -> idx and score stable throughout. A scores_valid during the hold -> overrun pulses once and the first result is unchanged.
- Back-to-back: in HOLD assert result_ready and scores_valid together with a new frame (max at class9=0x0001, others 0xFFFF) -> next result idx=9 after 9 further cycles; no overrun.
- Overrun in SCAN: second scores_valid 4 cycles into the scan -> overrun=1 for one cycle; the first frame's result is correct.
- Reset mid-scan: assert rst 5 cycles into SCAN -> next cycle busy=0, result_valid=0, idx=0, score=0. A subsequent frame produces a correct result.
